// File: rtl/inst_rom_server_if.sv
// inst_rom_server_if
//   Bundles the two buses that meet at the instruction ROM server.
//   - Program-load stream from the board loader:
//       prog_valid, prog_data, prog_last in; prog_ready back.
//   - Fetch port from the processor core:
//       rd_en, address in; instruction, inst_valid, addr_err back.
//   - Control: reload in; running back.
//   Modports:
//   - master: the loader/core side, which drives the requests.
//   - slave:  the ROM server itself.
interface inst_rom_server_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) ();
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_ready;
  logic              reload;
  logic              running;
  logic              rd_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              addr_err;

  modport master (
    output prog_valid, prog_data, prog_last, reload, rd_en, address,
    input  prog_ready, running, instruction, inst_valid, addr_err
  );

  modport slave (
    input  prog_valid, prog_data, prog_last, reload, rd_en, address,
    output prog_ready, running, instruction, inst_valid, addr_err
  );
endinterface

// File: rtl/inst_rom_server.sv
// inst_rom_server
//   Small instruction memory that sits between the program loader and the
//   core's fetch port.
//   - LOAD: after reset it accepts a program image, one word per accepted
//     beat.
//   - RUN: it then serves registered reads with one cycle of latency.
//   - reload in RUN returns it to LOAD for a new image. Words that a
//     shorter new image does not write keep their old contents.
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous, active-low reset
//     bus    inst_rom_server_if.slave; carries the load stream, the fetch
//            port and reload/running
module inst_rom_server #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 2,
  parameter int                DEPTH   = 4,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input logic               clk,
  input logic               reset,
  inst_rom_server_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instruction_q;
  logic              inst_valid_q;
  logic              addr_err_q;

  logic beat;
  logic last_beat;
  logic addr_oor;

  assign beat      = (state == ST_LOAD) && bus.prog_valid;
  // A full image ends the load even when prog_last is never asserted.
  assign last_beat = bus.prog_last || (wr_ptr == PTR_W'(DEPTH - 1));
  // Widen by one bit so that DEPTH == 2**ADDR_W is representable.
  assign addr_oor  = ({1'b0, bus.address} >= (ADDR_W + 1)'(DEPTH));

  // NOTE: the storage array is reset along with the control state because a
  // reset must restore every word to NOP_VAL, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_LOAD;
      wr_ptr        <= '0;
      instruction_q <= NOP_VAL;
      inst_valid_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_VAL;
      end
    end else begin
      // Both flags are single-cycle pulses. They drop unless a read
      // completes this cycle.
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (beat) begin
            mem[wr_ptr] <= bus.prog_data;
            if (last_beat) begin
              state  <= ST_RUN;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        default: begin
          // reload wins over a simultaneous fetch. The fetch is dropped and
          // the instruction register holds its value.
          if (bus.reload) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
          end else if (bus.rd_en) begin
            instruction_q <= addr_oor ? NOP_VAL : mem[bus.address];
            inst_valid_q  <= 1'b1;
            addr_err_q    <= addr_oor;
          end
        end
      endcase
    end
  end

  assign bus.prog_ready  = (state == ST_LOAD);
  assign bus.running     = (state == ST_RUN);
  assign bus.instruction = instruction_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_inst_rom_server.sv
// tb_inst_rom_server
//   Directed bench for inst_rom_server. It uses two instances:
//   - dut4: DEPTH=4, driven mostly from a vector table.
//   - dut3: DEPTH=3, used for out-of-range fetches.
//   Each table row gives the inputs applied before a rising edge and the
//   outputs expected just after that edge. A row may first pulse reset.
module tb_inst_rom_server;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_rom_server_if #(.DATA_W(8), .ADDR_W(2)) bus4 ();
  inst_rom_server_if #(.DATA_W(8), .ADDR_W(2)) bus3 ();

  inst_rom_server #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .NOP_VAL(8'h00)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  inst_rom_server #(.DATA_W(8), .ADDR_W(2), .DEPTH(3), .NOP_VAL(8'h00)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  typedef struct {
    logic       rst;
    logic       pv;
    logic [7:0] pd;
    logic       pl;
    logic       rd;
    logic [1:0] addr;
    logic       rl;
    logic       e_run;
    logic       e_rdy;
    logic       e_iv;
    logic       e_err;
    logic [7:0] e_inst;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic pv, input logic [7:0] pd, input logic pl,
    input logic rd, input logic [1:0] addr, input logic rl,
    input logic e_run, input logic e_rdy, input logic e_iv, input logic e_err,
    input logic [7:0] e_inst);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pd = pd; v.pl = pl;
    v.rd = rd; v.addr = addr; v.rl = rl;
    v.e_run = e_run; v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_err = e_err;
    v.e_inst = e_inst;
    return v;
  endfunction

  task automatic drive4(input logic pv, input logic [7:0] pd, input logic pl,
                        input logic rd, input logic [1:0] addr, input logic rl);
    bus4.prog_valid = pv; bus4.prog_data = pd; bus4.prog_last = pl;
    bus4.rd_en = rd; bus4.address = addr; bus4.reload = rl;
  endtask

  task automatic drive3(input logic pv, input logic [7:0] pd, input logic pl,
                        input logic rd, input logic [1:0] addr, input logic rl);
    bus3.prog_valid = pv; bus3.prog_data = pd; bus3.prog_last = pl;
    bus3.rd_en = rd; bus3.address = addr; bus3.reload = rl;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic check4(input string tag, input logic run, input logic rdy,
                        input logic iv, input logic err, input logic [7:0] inst);
    check({tag, " running"},     32'(bus4.running),     32'(run));
    check({tag, " prog_ready"},  32'(bus4.prog_ready),  32'(rdy));
    check({tag, " inst_valid"},  32'(bus4.inst_valid),  32'(iv));
    check({tag, " addr_err"},    32'(bus4.addr_err),    32'(err));
    check({tag, " instruction"}, 32'(bus4.instruction), 32'(inst));
  endtask

  task automatic check3(input string tag, input logic run,
                        input logic iv, input logic err, input logic [7:0] inst);
    check({tag, " running"},     32'(bus3.running),     32'(run));
    check({tag, " inst_valid"},  32'(bus3.inst_valid),  32'(iv));
    check({tag, " addr_err"},    32'(bus3.addr_err),    32'(err));
    check({tag, " instruction"}, 32'(bus3.instruction), 32'(inst));
  endtask

  initial begin
    // Fields: rst, pv, pd, pl, rd, addr, rl | run, rdy, iv, err, inst
    // Full 4-beat image without prog_last, then reads 0..3 back-to-back.
    vecs[0]  = mk(1, 1, 8'h11, 0, 0, 2'd0, 0,  0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(0, 1, 8'h22, 0, 0, 2'd0, 0,  0, 1, 0, 0, 8'h00);
    vecs[2]  = mk(0, 1, 8'h33, 0, 0, 2'd0, 0,  0, 1, 0, 0, 8'h00);
    vecs[3]  = mk(0, 1, 8'h44, 0, 0, 2'd0, 0,  1, 0, 0, 0, 8'h00);
    vecs[4]  = mk(0, 0, 8'h00, 0, 1, 2'd0, 0,  1, 0, 1, 0, 8'h11);
    vecs[5]  = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  1, 0, 1, 0, 8'h22);
    vecs[6]  = mk(0, 0, 8'h00, 0, 1, 2'd2, 0,  1, 0, 1, 0, 8'h33);
    vecs[7]  = mk(0, 0, 8'h00, 0, 1, 2'd3, 0,  1, 0, 1, 0, 8'h44);
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 2'd0, 0,  1, 0, 0, 0, 8'h44);
    // Short image ended by prog_last after reset; the unwritten word is NOP.
    vecs[9]  = mk(1, 1, 8'hA5, 0, 0, 2'd0, 0,  0, 1, 0, 0, 8'h00);
    vecs[10] = mk(0, 1, 8'h5A, 1, 0, 2'd0, 0,  1, 0, 0, 0, 8'h00);
    vecs[11] = mk(0, 0, 8'h00, 0, 1, 2'd2, 0,  1, 0, 1, 0, 8'h00);
    vecs[12] = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  1, 0, 1, 0, 8'h5A);
    // reload together with rd_en drops the read; a 1-beat image overwrites
    // word 0 only.
    vecs[13] = mk(0, 0, 8'h00, 0, 1, 2'd0, 1,  0, 1, 0, 0, 8'h5A);
    vecs[14] = mk(0, 1, 8'h77, 1, 0, 2'd0, 0,  1, 0, 0, 0, 8'h5A);
    vecs[15] = mk(0, 0, 8'h00, 0, 1, 2'd0, 0,  1, 0, 1, 0, 8'h77);
    vecs[16] = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  1, 0, 1, 0, 8'h5A);
    vecs[17] = mk(0, 0, 8'h00, 0, 1, 2'd2, 0,  1, 0, 1, 0, 8'h00);
    // A program beat offered in RUN must not be written.
    vecs[18] = mk(0, 1, 8'h99, 1, 1, 2'd0, 0,  1, 0, 1, 0, 8'h77);
    // In LOAD, rd_en and reload are ignored and a gap stalls wr_ptr.
    vecs[19] = mk(0, 0, 8'h00, 0, 0, 2'd0, 1,  0, 1, 0, 0, 8'h77);
    vecs[20] = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  0, 1, 0, 0, 8'h77);
    vecs[21] = mk(0, 0, 8'h00, 0, 1, 2'd0, 1,  0, 1, 0, 0, 8'h77);
    vecs[22] = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  0, 1, 0, 0, 8'h77);
    vecs[23] = mk(0, 1, 8'hBB, 1, 0, 2'd0, 0,  1, 0, 0, 0, 8'h77);
    vecs[24] = mk(0, 0, 8'h00, 0, 1, 2'd0, 0,  1, 0, 1, 0, 8'hBB);
    vecs[25] = mk(0, 0, 8'h00, 0, 1, 2'd1, 0,  1, 0, 1, 0, 8'h5A);

    drive4(0, 8'h00, 0, 0, 2'd0, 0);
    drive3(0, 8'h00, 0, 0, 2'd0, 0);
    reset = 1'b0;
    #12;
    reset = 1'b1;
    #1;
    check4("reset", 0, 1, 0, 0, 8'h00);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) pulse_reset();
      drive4(vecs[i].pv, vecs[i].pd, vecs[i].pl, vecs[i].rd, vecs[i].addr, vecs[i].rl);
      step();
      check4($sformatf("v%0d", i), vecs[i].e_run, vecs[i].e_rdy,
             vecs[i].e_iv, vecs[i].e_err, vecs[i].e_inst);
    end

    // Asynchronous reset: dut4 is in RUN with inst_valid high and
    // instruction 5A. Its outputs must clear without a clock edge.
    drive4(0, 8'h00, 0, 0, 2'd0, 0);
    reset = 1'b0;
    #1;
    check4("async_rst", 0, 1, 0, 0, 8'h00);
    reset = 1'b1;
    #1;
    // Reset in the middle of a load, then a full image from scratch.
    drive4(1, 8'h01, 0, 0, 2'd0, 0); step();
    drive4(1, 8'h02, 0, 0, 2'd0, 0); step();
    pulse_reset();
    drive4(1, 8'h01, 0, 0, 2'd0, 0); step();
    drive4(1, 8'h02, 0, 0, 2'd0, 0); step();
    drive4(1, 8'h03, 0, 0, 2'd0, 0); step();
    check("midload 3rd beat running", 32'(bus4.running), 32'd0);
    drive4(1, 8'h04, 0, 0, 2'd0, 0); step();
    check("midload 4th beat running", 32'(bus4.running), 32'd1);
    for (int a = 0; a < 4; a++) begin
      drive4(0, 8'h00, 0, 1, 2'(a), 0);
      step();
      check4($sformatf("midload rd%0d", a), 1, 0, 1, 0, 8'(a + 1));
    end
    drive4(0, 8'h00, 0, 0, 2'd0, 0);

    // DEPTH=3 instance: address 3 is out of range.
    pulse_reset();
    drive3(1, 8'hC1, 0, 0, 2'd0, 0); step();
    drive3(1, 8'hC2, 0, 0, 2'd0, 0); step();
    check("d3 2nd beat running", 32'(bus3.running), 32'd0);
    drive3(1, 8'hC3, 0, 0, 2'd0, 0); step();
    check("d3 3rd beat running", 32'(bus3.running), 32'd1);
    drive3(0, 8'h00, 0, 1, 2'd2, 0); step();
    check3("d3 rd2", 1, 1, 0, 8'hC3);
    drive3(0, 8'h00, 0, 1, 2'd3, 0); step();
    check3("d3 rd3", 1, 1, 1, 8'h00);
    drive3(0, 8'h00, 0, 0, 2'd0, 0); step();
    check3("d3 idle", 1, 0, 0, 8'h00);
    drive3(0, 8'h00, 0, 1, 2'd0, 0); step();
    check3("d3 rd0", 1, 1, 0, 8'hC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
